// File: rtl/ulpi_reg_seq.sv
// ulpi_reg_seq -- link-side ULPI register-write sequencer and RX CMD decoder.
//
// Purpose:
//   Serialises PHY register-write requests into the two-byte ULPI TX CMD
//   sequence (address command, then data) under the cmd_strobe/cmd_busy
//   handshake. Decodes RX CMD into line/VBUS/receive status, frames received
//   packets with a saturating length, and optionally detects USB bus reset.
//
// Configuration:
//   ULPI_BUS_RESET_DET_EN  define to enable SE0 bus-reset detection; when
//                          undefined bus_reset is tied low.
//   RESET_CYCLES           consecutive SE0 status clocks before bus_reset (>=2).
//
// Ports:
//   clk, reset_n           60 MHz ULPI clock, async active-low reset
//   data, data_valid       received byte stream from the link
//   rx_cmd                 latest RX CMD byte from the link
//   cmd, cmd_strobe        command byte and its one-cycle take pulse
//   cmd_busy               link cannot accept a command
//   req_valid/req_ready    register-write request handshake
//   req_addr, req_data     PHY register address / value
//   req_done               pulse once both command bytes are handed over
//   linestate, vbus_state, rx_active, rx_error   registered RX CMD fields
//   rx_cmd_change          pulse when rx_cmd differs from the previous cycle
//   pkt_end, pkt_len, pkt_err                    packet framing results
//   bus_reset              pulse on SE0 detection
module ulpi_reg_seq #(
  parameter int unsigned RESET_CYCLES = 150
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  data,
  input  logic        data_valid,
  input  logic [7:0]  rx_cmd,
  output logic [7:0]  cmd,
  output logic        cmd_strobe,
  input  logic        cmd_busy,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_addr,
  input  logic [7:0]  req_data,
  output logic        req_done,
  output logic [1:0]  linestate,
  output logic [1:0]  vbus_state,
  output logic        rx_active,
  output logic        rx_error,
  output logic        rx_cmd_change,
  output logic        pkt_end,
  output logic [10:0] pkt_len,
  output logic        pkt_err,
  output logic        bus_reset
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD_A, S_WAIT_A, S_GUARD_A, S_CMD_D, S_WAIT_D, S_GUARD_D
  } state_t;

  state_t      state;
  logic [5:0]  addr_q;
  logic [7:0]  data_q;
  logic [7:0]  rx_cmd_q;
  logic [10:0] cnt;
  logic        err_acc;

  // Register-write sequencer. The GUARD states give the link one cycle to
  // raise cmd_busy after each strobe before it is sampled again.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      addr_q     <= '0;
      data_q     <= '0;
      cmd        <= '0;
      cmd_strobe <= 1'b0;
      req_ready  <= 1'b1;
      req_done   <= 1'b0;
    end else begin
      cmd_strobe <= 1'b0;
      req_done   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            addr_q    <= req_addr;
            data_q    <= req_data;
            req_ready <= 1'b0;
            state     <= S_CMD_A;
          end
        end
        S_CMD_A: begin
          if (!cmd_busy) begin
            cmd        <= {2'b10, addr_q};
            cmd_strobe <= 1'b1;
            state      <= S_WAIT_A;
          end
        end
        S_WAIT_A:  state <= S_GUARD_A;
        S_GUARD_A: state <= S_CMD_D;
        S_CMD_D: begin
          if (!cmd_busy) begin
            cmd        <= data_q;
            cmd_strobe <= 1'b1;
            state      <= S_WAIT_D;
          end
        end
        S_WAIT_D:  state <= S_GUARD_D;
        S_GUARD_D: begin
          if (!cmd_busy) begin
            req_ready <= 1'b1;
            req_done  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: begin
          req_ready <= 1'b1;
          state     <= S_IDLE;
        end
      endcase
    end
  end

  // RX CMD status and packet framing. The live rx_cmd[4] is compared with the
  // registered rx_active to find packet edges, so a byte arriving in the
  // cycle rx_cmd[4] drops is still counted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_cmd_q      <= '0;
      linestate     <= '0;
      vbus_state    <= '0;
      rx_active     <= 1'b0;
      rx_error      <= 1'b0;
      rx_cmd_change <= 1'b0;
      pkt_end       <= 1'b0;
      pkt_len       <= '0;
      pkt_err       <= 1'b0;
      cnt           <= '0;
      err_acc       <= 1'b0;
    end else begin
      rx_cmd_q      <= rx_cmd;
      linestate     <= rx_cmd[1:0];
      vbus_state    <= rx_cmd[3:2];
      rx_active     <= rx_cmd[4];
      rx_error      <= rx_cmd[5] & rx_cmd[4];
      rx_cmd_change <= (rx_cmd != rx_cmd_q);
      pkt_end       <= 1'b0;
      if (rx_cmd[4] && !rx_active) begin
        cnt     <= {10'd0, data_valid};
        err_acc <= rx_cmd[5];
      end else if (rx_cmd[4]) begin
        if (data_valid && (cnt != '1)) cnt <= cnt + 11'd1;
        if (rx_cmd[5]) err_acc <= 1'b1;
      end else if (rx_active) begin
        pkt_end <= 1'b1;
        pkt_len <= (data_valid && (cnt != '1)) ? cnt + 11'd1 : cnt;
        pkt_err <= err_acc;
      end
    end
  end

`ifdef ULPI_BUS_RESET_DET_EN
  localparam int unsigned CW = $clog2(RESET_CYCLES + 1);
  localparam logic [CW-1:0] RC    = CW'(RESET_CYCLES);
  localparam logic [CW-1:0] RC_M1 = CW'(RESET_CYCLES - 1);

  logic [CW-1:0] se0_cnt;
  logic          unused_data;
  assign unused_data = ^data;

  // Counter saturates at RESET_CYCLES so the pulse fires once per SE0 period.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      se0_cnt   <= '0;
      bus_reset <= 1'b0;
    end else begin
      bus_reset <= 1'b0;
      if (linestate != 2'b00) begin
        se0_cnt <= '0;
      end else if (se0_cnt != RC) begin
        se0_cnt   <= se0_cnt + 1'b1;
        bus_reset <= (se0_cnt == RC_M1);
      end
    end
  end
`else
  logic unused_data;
  assign unused_data = ^{data, 32'(RESET_CYCLES)};
  assign bus_reset   = 1'b0;
`endif

endmodule

// File: doc/ulpi_reg_seq.md
# ulpi_reg_seq

Client-side engine on the link end of the ULPI link interface. It consumes the link's byte stream and RX CMD status, and drives its command port. It serialises PHY register-write requests into the two-byte ULPI TX CMD sequence under the `cmd_strobe`/`cmd_busy` handshake. It also decodes RX CMD into line/VBUS/receive status, frames received packets with a length, and optionally detects USB bus reset (SE0).

## Interface
- `RESET_CYCLES`, default 150: consecutive SE0 clocks (2.5 µs at 60 MHz) before `bus_reset` fires; minimum 2.
- `clk` in 1: ULPI 60 MHz clock; all logic on its rising edge.
- `reset_n` in 1: reset; asynchronous, active-low.
- `data` in 8: received byte from link.
- `data_valid` in 1: `data` valid this cycle.
- `rx_cmd` in 8: latest RX CMD from link.
- `cmd` out 8: command byte to link.
- `cmd_strobe` out 1: one-cycle pulse; link takes `cmd` this cycle.
- `cmd_busy` in 1: link cannot accept a command.
- `req_valid` in 1: register-write request.
- `req_ready` out 1: engine idle, request accepted when both high.
- `req_addr` in 6: PHY register address.
- `req_data` in 8: value to write.
- `req_done` out 1: one-cycle pulse, write fully handed to link.
- `linestate` out 2: `rx_cmd[1:0]`, registered.
- `vbus_state` out 2: `rx_cmd[3:2]`, registered.
- `rx_active` out 1: `rx_cmd[4]`, registered.
- `rx_error` out 1: `rx_cmd[5] & rx_cmd[4]`, registered.
- `rx_cmd_change` out 1: pulse, `rx_cmd` differs from previous cycle.
- `pkt_end` out 1: pulse, packet ended.
- `pkt_len` out 11: byte count of the ended packet; held until next `pkt_end`.
- `pkt_err` out 1: `rx_error` was seen during the ended packet; valid with `pkt_end`.
- `bus_reset` out 1: pulse, SE0 detected.

## Operation
- Write FSM states: IDLE, CMD_A, WAIT_A, GUARD_A, CMD_D, WAIT_D, GUARD_D.
  - IDLE: `req_ready`=1. On `req_valid`, latch address and data, then go to CMD_A.
  - CMD_A: when `cmd_busy`=0, register `cmd`={2'b10,addr} and `cmd_strobe`=1, then go to WAIT_A. Otherwise hold.
  - WAIT_A: `cmd_strobe`=0, then go to GUARD_A.
  - GUARD_A: go unconditionally to CMD_D. This covers the link's one-cycle busy response.
  - CMD_D, WAIT_D, GUARD_D: same as CMD_A, WAIT_A, GUARD_A, with `cmd`=data.
  - GUARD_D: when `cmd_busy`=0, go to IDLE and pulse `req_done`. Otherwise hold.
- `cmd` holds its last value when `cmd_strobe`=0.
- Status outputs are registered copies of `rx_cmd`. `rx_cmd_change` compares against the previous registered value. The first cycle after reset compares against 8'h00.
- Packet counter:
  - Clears on the rising edge of `rx_active`.
  - Increments on `data_valid` while `rx_active`=1, saturating at 2047.
  - `data_valid` with `rx_active`=0 is ignored.
  - On the falling edge of `rx_active`, pulse `pkt_end` and load `pkt_len`/`pkt_err`.
  - If `data_valid` arrives in the cycle `rx_active` falls, that byte is counted in `pkt_len`.

## Timing
- Reset values: `cmd`=0, `cmd_strobe`=0, `req_ready`=1, `req_done`=0, all status 0, `pkt_len`=0, all pulses 0. FSM returns to IDLE.
- Reset mid-write abandons the write. No `req_done`. `cmd_strobe` drops immediately (asynchronously).
- With `cmd_busy` held 0: acceptance at edge 0 gives `cmd_strobe` high in cycle 2 (address) and cycle 5 (data), and `req_done` in cycle 7. The next request can be accepted at edge 7.
- `cmd_busy` is sampled only in CMD_A, CMD_D and GUARD_D. `cmd_strobe` is never asserted while `cmd_busy` was high on the previous edge.
- Status outputs lag `rx_cmd` by 1 cycle. `pkt_end` is 1 cycle after `rx_active` falls.

## Configuration
- `ULPI_BUS_RESET_DET_EN` defined:
  - A counter runs while registered `linestate`=2'b00.
  - When it reaches `RESET_CYCLES`, `bus_reset` pulses once.
  - The counter then holds until `linestate`≠00, when it clears.
- `ULPI_BUS_RESET_DET_EN` undefined: counter removed, `bus_reset` tied 0.

## Test plan
- `cmd_busy`=0, request addr=6'h04 data=8'h45: `cmd_strobe` carries 8'h84 in cycle 2 and 8'h45 in cycle 5; `req_done` in cycle 7; `req_ready`=0 in cycles 1–6.
- Same request, with `cmd_busy` asserted for 3 cycles from cycle 3: data strobe delayed until busy low; no strobe while busy; exactly two strobes total.
- `rx_cmd` 8'h00→8'h11, 5 `data_valid` bytes, then 8'h01: `rx_active` rises, one `rx_cmd_change` per transition, `pkt_end` with `pkt_len`=5, `pkt_err`=0.
- Packet with `rx_cmd`=8'h31 mid-packet: `rx_error`=1; at end `pkt_err`=1. A packet of 3000 bytes gives `pkt_len`=2047.
- Macro defined, `RESET_CYCLES`=150, `linestate`=00 for 200 cycles: one `bus_reset` pulse 150 cycles after the first SE0 status. At 149 cycles then `linestate` 01: no pulse. Macro undefined: never pulses.
- `reset_n` low during WAIT_D: all outputs at reset values immediately; after release, a new request completes normally.
